pipe_hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage core. Drives the `load`/`clr` pins of the four inter-stage load/clear registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register. It resolves four hazard classes every cycle:
- trap flush
- memory-bus wait
- multi-cycle divide occupancy of EX
- taken-branch redirect and load-use stall

---
 rtl/pipe_hazard_ctrl_pkg.sv | 27 ++
 rtl/pipe_hazard_ctrl_div_timer.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 102 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared types for the pipeline hazard controller
// Contents:
//   REG_AW      - register-file address width
//   phc_state_e - controller state (RUN / DIV_WAIT)
//   ctl_t       - bundle of PC load plus per-stage load/clear pins
//                 (bit 3 = IF/ID, 2 = ID/EX, 1 = EX/MEM, 0 = MEM/WB)
//   CTL_*       - control patterns for each hazard action
package pipe_hazard_ctrl_pkg;
    localparam int REG_AW = 5;

    typedef enum logic {PHC_RUN, PHC_DIV_WAIT} phc_state_e;

    typedef struct packed {
        logic       pc_load;
        logic [3:0] load;
        logic [3:0] clr;
    } ctl_t;

    // A cleared stage always has its load low, since clear wins at the register
    localparam ctl_t CTL_RUN      = '{1'b1, 4'b1111, 4'b0000};
    localparam ctl_t CTL_RESET    = '{1'b0, 4'b0000, 4'b1111};
    localparam ctl_t CTL_TRAP     = '{1'b1, 4'b0000, 4'b1111};
    localparam ctl_t CTL_MSTALL   = '{1'b0, 4'b0000, 4'b0001};
    localparam ctl_t CTL_DIV_HOLD = '{1'b0, 4'b0001, 4'b0010};
    localparam ctl_t CTL_BRANCH   = '{1'b1, 4'b0011, 4'b1100};
    localparam ctl_t CTL_LUH      = '{1'b0, 4'b0011, 4'b0100};
endpackage

// File: rtl/pipe_hazard_ctrl_div_timer.sv
// pipe_div_timer: loadable down-counter timing the divider's occupancy of EX
// Ports:
//   i_clk, i_rst - clock, synchronous active-high reset (clears count)
//   i_load       - load i_load_val (has priority over i_dec)
//   i_load_val   - value to load
//   i_dec        - decrement; saturates at zero
//   o_zero       - count is zero
module pipe_div_timer #(
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = r_cnt == '0;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for the 5-stage core
// Ports:
//   i_clk, i_rst                 - clock, synchronous active-high reset
//   i_id_rs{1,2}_addr/_used      - source operands of the ID instruction
//   i_ex_is_load, i_ex_rd_addr   - EX instruction is a load, and its destination
//   i_ex_div_start               - EX instruction issues a divide
//   i_ex_branch_taken            - EX instruction redirects the PC
//   i_mem_req, i_mem_ack         - MEM bus request / acknowledge
//   i_trap_req                   - trap taken at MEM/WB
//   o_pc_load                    - update the PC
//   o_*_load, o_*_clr            - advance / bubble each inter-stage register
//   o_div_busy, o_div_kill       - divide wait in progress / abort divider
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DIV_LATENCY = 33,
    parameter int CNT_W       = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [REG_AW-1:0] i_id_rs1_addr,
    input  logic [REG_AW-1:0] i_id_rs2_addr,
    input  logic              i_id_rs1_used,
    input  logic              i_id_rs2_used,
    input  logic              i_ex_is_load,
    input  logic [REG_AW-1:0] i_ex_rd_addr,
    input  logic              i_ex_div_start,
    input  logic              i_ex_branch_taken,
    input  logic              i_mem_req,
    input  logic              i_mem_ack,
    input  logic              i_trap_req,
    output logic              o_pc_load,
    output logic              o_if_id_load,
    output logic              o_id_ex_load,
    output logic              o_ex_mem_load,
    output logic              o_mem_wb_load,
    output logic              o_if_id_clr,
    output logic              o_id_ex_clr,
    output logic              o_ex_mem_clr,
    output logic              o_mem_wb_clr,
    output logic              o_div_busy,
    output logic              o_div_kill
);
    phc_state_e r_state;
    logic       w_luh;
    logic       w_mstall;
    logic       w_div;
    logic       w_zero;
    logic       w_issue;
    ctl_t       w_ctl;

    assign w_luh = i_ex_is_load && i_ex_rd_addr != '0 &&
                   ((i_id_rs1_used && i_id_rs1_addr == i_ex_rd_addr) ||
                    (i_id_rs2_used && i_id_rs2_addr == i_ex_rd_addr));
    assign w_mstall = i_mem_req && !i_mem_ack;
    assign w_div    = r_state == PHC_DIV_WAIT;
    assign w_issue  = !w_div && !w_mstall && !i_trap_req && i_ex_div_start;

    // Issue cycle counts as the first of DIV_LATENCY, and the release cycle
    // sees zero, hence the -2. The counter keeps running through memory
    // stalls because the divider itself is not stalled.
    pipe_div_timer #(.CNT_W(CNT_W)) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (i_trap_req || w_issue),
        .i_load_val (i_trap_req ? '0 : CNT_W'(DIV_LATENCY - 2)),
        .i_dec      (w_div),
        .o_zero     (w_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst || i_trap_req)
            r_state <= PHC_RUN;
        else if (w_issue)
            r_state <= PHC_DIV_WAIT;
        else if (w_div && w_zero && !w_mstall)
            r_state <= PHC_RUN;
    end

    // Priority mux; in DIV_WAIT branch and load-use are ignored, and a
    // finished divide releases with the plain run pattern
    assign w_ctl = i_rst                                   ? CTL_RESET    :
                   i_trap_req                              ? CTL_TRAP     :
                   w_mstall                                ? CTL_MSTALL   :
                   (w_div ? !w_zero : i_ex_div_start)      ? CTL_DIV_HOLD :
                   w_div                                   ? CTL_RUN      :
                   i_ex_branch_taken                       ? CTL_BRANCH   :
                   w_luh                                   ? CTL_LUH      :
                                                             CTL_RUN;

    assign o_pc_load     = w_ctl.pc_load;
    assign o_if_id_load  = w_ctl.load[3];
    assign o_id_ex_load  = w_ctl.load[2];
    assign o_ex_mem_load = w_ctl.load[1];
    assign o_mem_wb_load = w_ctl.load[0];
    assign o_if_id_clr   = w_ctl.clr[3];
    assign o_id_ex_clr   = w_ctl.clr[2];
    assign o_ex_mem_clr  = w_ctl.clr[1];
    assign o_mem_wb_clr  = w_ctl.clr[0];
    assign o_div_busy    = w_div && !i_rst && !i_trap_req;
    assign o_div_kill    = w_div && !i_rst && i_trap_req;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl against a cycle-number reference model
module tb_pipe_hazard_ctrl;
    localparam int LAT = 33;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       rs1_used = 1'b0, rs2_used = 1'b0, is_load = 1'b0;
    logic       div_start = 1'b0, branch = 1'b0, mem_req = 1'b0, mem_ack = 1'b0, trap = 1'b0;
    logic       pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic       if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr, div_busy, div_kill;
    logic [10:0] act;

    logic [10:0] exp_q[$];
    int          cyc_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model: divide tracked by the absolute cycle at which its counter hits zero
    bit m_div = 0;
    int m_done = 0;
    int cyc = 0;

    pipe_hazard_ctrl #(.DIV_LATENCY(LAT), .CNT_W(6)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
        .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
        .i_ex_is_load(is_load), .i_ex_rd_addr(rd),
        .i_ex_div_start(div_start), .i_ex_branch_taken(branch),
        .i_mem_req(mem_req), .i_mem_ack(mem_ack), .i_trap_req(trap),
        .o_pc_load(pc_load),
        .o_if_id_load(if_id_load), .o_id_ex_load(id_ex_load),
        .o_ex_mem_load(ex_mem_load), .o_mem_wb_load(mem_wb_load),
        .o_if_id_clr(if_id_clr), .o_id_ex_clr(id_ex_clr),
        .o_ex_mem_clr(ex_mem_clr), .o_mem_wb_clr(mem_wb_clr),
        .o_div_busy(div_busy), .o_div_kill(div_kill)
    );

    assign act = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                  if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr, div_busy, div_kill};

    always #5 clk = ~clk;

    task automatic push_exp();
        logic       pc, busy, kill;
        logic [3:0] ld, cl;
        bit         luh, ms, zero;
        luh  = is_load && rd != 0 && ((rs1_used && rs1 == rd) || (rs2_used && rs2 == rd));
        ms   = mem_req && !mem_ack;
        zero = m_div && cyc >= m_done;
        pc = 1; ld = 4'b1111; cl = 4'b0000; busy = 0; kill = 0;
        if (rst) begin
            pc = 0; ld = 4'b0000; cl = 4'b1111; m_div = 0;
        end else if (trap) begin
            pc = 1; ld = 4'b0000; cl = 4'b1111; kill = m_div; m_div = 0;
        end else if (ms) begin
            pc = 0; ld = 4'b0000; cl = 4'b0001; busy = m_div;
        end else if (m_div && !zero) begin
            pc = 0; ld = 4'b0001; cl = 4'b0010; busy = 1;
        end else if (m_div) begin
            busy = 1; m_div = 0;
        end else if (div_start) begin
            pc = 0; ld = 4'b0001; cl = 4'b0010; m_div = 1; m_done = cyc + LAT - 1;
        end else if (branch) begin
            pc = 1; ld = 4'b0011; cl = 4'b1100;
        end else if (luh) begin
            pc = 0; ld = 4'b0011; cl = 4'b0100;
        end
        exp_q.push_back({pc, ld, cl, busy, kill});
        cyc_q.push_back(cyc);
        cyc++;
    endtask

    task automatic step();
        push_exp();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; rs1 = '0; rs2 = '0; rd = '0; rs1_used = 0; rs2_used = 0; is_load = 0;
        div_start = 0; branch = 0; mem_req = 0; mem_ack = 0; trap = 0;
    endtask

    task automatic idle_n(input int n);
        idle();
        for (int i = 0; i < n; i++) step();
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [10:0] e;
            int          c;
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL ctl cycle %0d: got %b want %b (pc,ld4,clr4,busy,kill)", c, act, e);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        rst = 1; step(); step();
        idle_n(2);
        // load-use hit, then normal
        is_load = 1; rd = 5; rs1_used = 1; rs1 = 5; step();
        idle_n(1);
        // destination x0 never stalls
        is_load = 1; rd = 0; rs1_used = 1; rs1 = 0; step();
        idle_n(1);
        // branch beats load-use
        is_load = 1; rd = 7; rs2_used = 1; rs2 = 7; branch = 1; step();
        idle_n(1);
        // divide with memory stall overlapping its end
        div_start = 1; step();
        idle_n(29);
        mem_req = 1; mem_ack = 0;
        for (int i = 0; i < 6; i++) step();
        idle_n(4);
        // plain divide, branch and load-use ignored while waiting
        div_start = 1; step();
        idle(); branch = 1; is_load = 1; rd = 3; rs1_used = 1; rs1 = 3;
        for (int i = 0; i < 34; i++) step();
        idle_n(2);
        // trap in 5th cycle of DIV_WAIT
        div_start = 1; step();
        idle_n(4);
        trap = 1; step();
        idle_n(2);
        // reset mid-divide
        div_start = 1; step();
        idle_n(10);
        rst = 1; step(); step();
        idle_n(3);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = $urandom_range(0, 199) == 0;
            trap      = $urandom_range(0, 59) == 0;
            mem_req   = $urandom_range(0, 2) == 0;
            mem_ack   = $urandom_range(0, 1) == 1;
            div_start = $urandom_range(0, 19) == 0;
            branch    = $urandom_range(0, 5) == 0;
            is_load   = $urandom_range(0, 1) == 1;
            rs1_used  = $urandom_range(0, 1) == 1;
            rs2_used  = $urandom_range(0, 1) == 1;
            rd        = 5'($urandom_range(0, 3));
            rs1       = 5'($urandom_range(0, 3));
            rs2       = 5'($urandom_range(0, 3));
            step();
        end
        idle();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
